// File: rtl/ps2_rx_stream.sv
// PS/2 device-to-host receiver: line conditioning, 11-bit framing FSM, byte FIFO, valid/ready output.
// Define PS2_PREFIX_DECODE_EN to fold 0xE0/0xF0 prefixes into the code_ext/code_break flags.

module ps2_rx_stream #(
   parameter int CLK_FREQ        = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int TIMEOUT_US      = 2000,
   parameter int FIFO_DEPTH      = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   output logic                          code_valid,
   input  logic                          code_ready,
   output logic [7:0]                    code_data,
   output logic                          code_ext,
   output logic                          code_break,
   output logic                          frame_err,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy
);

   localparam int TIMEOUT_CYCLES = CLK_FREQ / 1_000_000 * TIMEOUT_US;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_PREFIX_DECODE_EN
   localparam int EW = 10;
`else
   localparam int EW = 8;
`endif
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [GW-1:0] TO_LAST  = GW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   // Frame is {stop, parity, D7..D0, start}; data plus parity must carry an odd number of ones.
   function automatic logic frame_ok(input logic [10:0] f);
      return (f[0] == 1'b0) && (f[10] == 1'b1) && ((^f[9:1]) == 1'b1);
   endfunction

   // Line conditioning state, index 0 = ps2_clk, index 1 = ps2_data
   logic [1:0]    sync0_r;
   logic [1:0]    sync1_r;
   logic [1:0]    filt_r;
   logic [DW-1:0] deb_cnt_r [2];
   logic          clk_filt_d_r;
   logic          fall_s;
   logic          bit_s;

   state_t        state_r;
   state_t        state_s;
   logic [3:0]    bit_cnt_r;
   logic [10:0]   shift_r;
   logic [GW-1:0] gap_cnt_r;
   logic          err_s;
   logic          good_s;
   logic          frame_err_r;
   logic          busy_r;
   logic [7:0]    byte_s;

   logic [EW-1:0] mem_r [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_s;
   logic          code_valid_r;
   logic          overflow_r;
   logic          push_req_s;
   logic          push_s;
   logic          pop_s;
   logic          full_s;
   logic [EW-1:0] entry_s;
   logic [EW-1:0] head_s;

`ifdef PS2_PREFIX_DECODE_EN
   logic          pend_ext_r;
   logic          pend_brk_r;
`endif

   // Two-flop synchroniser followed by a stability filter on both PS/2 lines
   always_ff @(posedge clk) begin
      if (reset) begin
         sync0_r      <= 2'b11;
         sync1_r      <= 2'b11;
         filt_r       <= 2'b11;
         clk_filt_d_r <= 1'b1;
         for (int i = 0; i < 2; i++) begin
            deb_cnt_r[i] <= '0;
         end
      end else begin
         sync0_r      <= {ps2_data, ps2_clk};
         sync1_r      <= sync0_r;
         clk_filt_d_r <= filt_r[0];
         for (int i = 0; i < 2; i++) begin
            if (sync1_r[i] == filt_r[i]) begin
               deb_cnt_r[i] <= '0;
            end else if (deb_cnt_r[i] == DEB_LAST) begin
               filt_r[i]    <= sync1_r[i];
               deb_cnt_r[i] <= '0;
            end else begin
               deb_cnt_r[i] <= deb_cnt_r[i] + 1'b1;
            end
         end
      end
   end

   assign fall_s = clk_filt_d_r & ~filt_r[0];
   assign bit_s  = filt_r[1];
   assign byte_s = shift_r[8:1];

   // Framing FSM next-state and frame verdict
   always_comb begin
      state_s = state_r;
      err_s   = 1'b0;
      good_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (fall_s) begin
               if (bit_s == 1'b0) begin
                  state_s = ST_SHIFT;
               end else begin
                  err_s = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (fall_s) begin
               if (bit_cnt_r == 4'd10) begin
                  state_s = ST_CHECK;
               end else begin
                  state_s = ST_SHIFT;
               end
            end else if (gap_cnt_r == TO_LAST) begin
               err_s   = 1'b1;
               state_s = ST_IDLE;
            end else begin
               state_s = ST_SHIFT;
            end
         end
         ST_CHECK: begin
            state_s = ST_IDLE;
            if (frame_ok(shift_r)) begin
               good_s = 1'b1;
            end else begin
               err_s = 1'b1;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Framing state register, shift register, bit and gap counters
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         bit_cnt_r   <= 4'd0;
         shift_r     <= 11'd0;
         gap_cnt_r   <= '0;
         frame_err_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         frame_err_r <= err_s;
         busy_r      <= (state_s != ST_IDLE);
         case (state_r)
            ST_IDLE: begin
               gap_cnt_r <= '0;
               if (fall_s && (bit_s == 1'b0)) begin
                  shift_r   <= {bit_s, shift_r[10:1]};
                  bit_cnt_r <= 4'd1;
               end
            end
            ST_SHIFT: begin
               if (fall_s) begin
                  shift_r   <= {bit_s, shift_r[10:1]};
                  bit_cnt_r <= bit_cnt_r + 4'd1;
                  gap_cnt_r <= '0;
               end else begin
                  gap_cnt_r <= gap_cnt_r + 1'b1;
               end
            end
            ST_CHECK: begin
               bit_cnt_r <= 4'd0;
            end
            default: begin
               bit_cnt_r <= 4'd0;
            end
         endcase
      end
   end

`ifdef PS2_PREFIX_DECODE_EN
   // Pending prefix flags; any rejected or aborted frame forgets them
   always_ff @(posedge clk) begin
      if (reset || err_s) begin
         pend_ext_r <= 1'b0;
         pend_brk_r <= 1'b0;
      end else if (good_s) begin
         if (byte_s == 8'hE0) begin
            pend_ext_r <= 1'b1;
         end else if (byte_s == 8'hF0) begin
            pend_brk_r <= 1'b1;
         end else begin
            pend_ext_r <= 1'b0;
            pend_brk_r <= 1'b0;
         end
      end
   end
`endif

   // Push request, FIFO handshake and next occupancy
   always_comb begin
      push_req_s = 1'b0;
      entry_s    = '0;
      full_s     = 1'b0;
      pop_s      = 1'b0;
      push_s     = 1'b0;
      count_s    = count_r;
`ifdef PS2_PREFIX_DECODE_EN
      if (good_s && (byte_s != 8'hE0) && (byte_s != 8'hF0)) begin
         push_req_s = 1'b1;
         entry_s    = {pend_ext_r, pend_brk_r, byte_s};
      end else begin
         push_req_s = 1'b0;
      end
`else
      if (good_s) begin
         push_req_s = 1'b1;
         entry_s    = byte_s;
      end else begin
         push_req_s = 1'b0;
      end
`endif
      full_s = (count_r == FULL_CNT);
      pop_s  = code_valid_r & code_ready;
      push_s = push_req_s & (~full_s | pop_s);
      case ({push_s, pop_s})
         2'b10:   count_s = count_r + 1'b1;
         2'b01:   count_s = count_r - 1'b1;
         default: count_s = count_r;
      endcase
   end

   // FIFO storage, pointers, occupancy and sticky overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r     <= '0;
         rd_ptr_r     <= '0;
         count_r      <= '0;
         code_valid_r <= 1'b0;
         overflow_r   <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
            wr_ptr_r        <= wr_ptr_r + 1'b1;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         if (push_req_s && full_s && !pop_s) begin
            overflow_r <= 1'b1;
         end
         count_r      <= count_s;
         code_valid_r <= (count_s != '0);
      end
   end

   assign head_s     = mem_r[rd_ptr_r];
   assign code_valid = code_valid_r;
   assign code_data  = code_valid_r ? head_s[7:0] : 8'h00;
`ifdef PS2_PREFIX_DECODE_EN
   assign code_ext   = code_valid_r & head_s[9];
   assign code_break = code_valid_r & head_s[8];
`else
   assign code_ext   = 1'b0;
   assign code_break = 1'b0;
`endif
   assign frame_err  = frame_err_r;
   assign overflow   = overflow_r;
   assign fifo_count = count_r;
   assign busy       = busy_r;

endmodule
